// File: rtl/prog_loader.sv
// prog_loader: boot-time byte-stream loader writing big-endian words to CPU memory, then releasing cpu_run.
// Optional trailing XOR checksum word enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int ADDR_W = 10,
  parameter int MAX_WORDS = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              cpu_run,
  output logic              load_err,
  output logic [15:0]       words_loaded
);
  localparam logic [2:0] HDR = 3'd0, LOAD = 3'd1, CSUM = 3'd2, DONE = 3'd3, ERR = 3'd4;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic [2:0] FIN = CSUM;
  logic [31:0] csum;
`else
  localparam logic [2:0] FIN = DONE;
`endif
  logic [2:0] state;
  logic [1:0] lane;
  logic [23:0] shift;
  logic [15:0] n;
  logic [ADDR_W-1:0] next_addr;
  logic [31:0] word;
  logic take, word_done;
  assign in_ready = state == HDR || state == LOAD || state == CSUM;
  assign take = in_valid && in_ready;
  assign word = {shift, in_data};
  assign word_done = take && lane == 2'd3;
  assign load_err = state == ERR;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HDR;
      lane <= 2'd0;
      shift <= 24'd0;
      n <= 16'd0;
      next_addr <= ADDR_W'(BASE_ADDR);
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_data <= 32'd0;
      cpu_run <= 1'b0;
      words_loaded <= 16'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum <= 32'd0;
`endif
    end else begin
      mem_we <= 1'b0;
      // registered so cpu_run rises one cycle after the final write strobe
      cpu_run <= state == DONE;
      if (take) begin
        lane <= lane + 2'd1;
        shift <= {shift[15:0], in_data};
      end
      if (word_done && state == HDR) begin
        n <= word[15:0];
        state <= word[15:0] == 16'd0 ? FIN : word[15:0] > 16'(MAX_WORDS) ? ERR : LOAD;
      end
      if (word_done && state == LOAD) begin
        mem_we <= 1'b1;
        mem_addr <= next_addr;
        mem_data <= word;
        next_addr <= next_addr + ADDR_W'(4);
        words_loaded <= words_loaded + 16'd1;
        if (words_loaded == n - 16'd1) state <= FIN;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      if (word_done) csum <= state == HDR ? word : csum ^ word;
      if (word_done && state == CSUM) state <= word == csum ? DONE : ERR;
`endif
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized and directed image loads checked against a queue-based write model.
module tb_prog_loader;
  typedef logic [31:0] wq_t[$];
  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    logic [15:0] cnt;
  } wr_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] in_data = 8'd0;
  logic in_valid = 1'b0;
  logic in_ready, mem_we, cpu_run, load_err;
  logic [9:0] mem_addr;
  logic [31:0] mem_data;
  logic [15:0] words_loaded;
  int checks = 0;
  int failures = 0;
  wr_t exp_q[$];
  wr_t mon_w;
  wq_t q;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .cpu_run(cpu_run),
    .load_err(load_err), .words_loaded(words_loaded)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      chk("we_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        mon_w = exp_q.pop_front();
        chk("mem_addr", {22'd0, mem_addr}, {22'd0, mon_w.addr});
        chk("mem_data", mem_data, mon_w.data);
        chk("words_loaded_at_we", {16'd0, words_loaded}, {16'd0, mon_w.cnt});
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic put(input logic [7:0] b, input bit gap);
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_data = b;
    in_valid = 1'b1;
    chk("in_ready_loading", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic put_word(input logic [31:0] w, input int mode);
    for (int i = 3; i >= 0; i--) put(w[i*8+:8], mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1));
  endtask

  // mode: 0 back-to-back, 1 idle cycle before every byte, 2 random idle cycles
  task automatic load(input wq_t ws, input logic [15:0] hi, input int mode);
    logic [31:0] hdr, x;
    hdr = {hi, 16'(ws.size())};
    x = hdr;
    put_word(hdr, mode);
    for (int k = 0; k < ws.size(); k++) begin
      x ^= ws[k];
      exp_q.push_back('{10'((k * 4) % 1024), ws[k], 16'(k + 1)});
      put_word(ws[k], mode);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    put_word(x, mode);
    chk("we_after_last", {31'd0, mem_we}, 32'd0);
`else
    chk("we_after_last", {31'd0, mem_we}, {31'd0, ws.size() != 0});
`endif
    chk("cpu_run_early", {31'd0, cpu_run}, 32'd0);
    @(negedge clk);
    chk("cpu_run", {31'd0, cpu_run}, 32'd1);
    chk("in_ready_done", {31'd0, in_ready}, 32'd0);
    chk("load_err_ok", {31'd0, load_err}, 32'd0);
    chk("words_loaded", {16'd0, words_loaded}, 32'(ws.size()));
    chk("writes_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    chk("cpu_run_held", {31'd0, cpu_run}, 32'd1);
  endtask

  initial begin
    do_reset();
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_mem_data", mem_data, 32'd0);
    chk("rst_cpu_run", {31'd0, cpu_run}, 32'd0);
    chk("rst_load_err", {31'd0, load_err}, 32'd0);
    chk("rst_words", {16'd0, words_loaded}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    q = '{32'h20080005, 32'h2009000A};
    load(q, 16'h0000, 0);
    do_reset();
    load(q, 16'h0000, 1);

    do_reset();
    q.delete();
    load(q, 16'h0000, 0);

    do_reset();
    put_word(32'h00000101, 0);
    chk("err_flag", {31'd0, load_err}, 32'd1);
    chk("err_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("err_held", {31'd0, load_err}, 32'd1);
    chk("err_cpu_run", {31'd0, cpu_run}, 32'd0);
    chk("err_words", {16'd0, words_loaded}, 32'd0);

    do_reset();
    put_word(32'h00000003, 0);
    exp_q.push_back('{10'd0, 32'hCAFEF00D, 16'd1});
    put_word(32'hCAFEF00D, 0);
    put(8'h11, 0);
    put(8'h22, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_we", {31'd0, mem_we}, 32'd0);
    chk("mid_rst_addr", {22'd0, mem_addr}, 32'd0);
    chk("mid_rst_data", mem_data, 32'd0);
    chk("mid_rst_words", {16'd0, words_loaded}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    q = '{32'($urandom)};
    load(q, 16'($urandom), 2);

    for (int r = 0; r < 5; r++) begin
      do_reset();
      q.delete();
      repeat ($urandom_range(1, 8)) q.push_back($urandom);
      load(q, 16'($urandom), 2);
    end

    do_reset();
    q.delete();
    repeat (256) q.push_back($urandom);
    load(q, 16'($urandom), 0);

`ifdef PROG_LOADER_CHECKSUM_EN
    do_reset();
    exp_q.push_back('{10'd0, 32'h12345678, 16'd1});
    put_word(32'h00000001, 0);
    put_word(32'h12345678, 0);
    put_word(32'h12345679, 0);
    @(negedge clk);
    chk("csum_ok_run", {31'd0, cpu_run}, 32'd1);
    do_reset();
    exp_q.push_back('{10'd0, 32'h12345678, 16'd1});
    put_word(32'h00000001, 0);
    put_word(32'h12345678, 0);
    put_word(32'h00000000, 0);
    @(negedge clk);
    chk("csum_bad_err", {31'd0, load_err}, 32'd1);
    chk("csum_bad_run", {31'd0, cpu_run}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader upstream of the single-cycle CPU.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Writes them into the unified instruction/data memory at consecutive word addresses.
- Holds the CPU stalled until the image is complete. The CPU core's memory write port and its clock gate are muxed from this block's outputs while cpu_run is low.

Parameters:
- ADDR_W, 10, width of memory byte address (matches CPU memory port)
- MAX_WORDS, 256, largest accepted image length in words
- BASE_ADDR, 0, byte address of first loaded word; must be a multiple of 4

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept a byte this cycle
- mem_we  out  1  one-cycle memory write strobe
- mem_addr  out  ADDR_W  byte address of the word being written
- mem_data  out  32  word being written
- cpu_run  out  1  high once the image is fully loaded; CPU may execute
- load_err  out  1  sticky error flag
- words_loaded  out  16  count of words written so far

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset. The reset value of every output is 0, and the state returns to HDR.
- Byte transfer: a byte transfers on a clk edge where in_valid && in_ready.
- Byte order: bytes are big-endian; the first byte of a word lands in bits [31:24].
- Byte lane counter: 2 bits, wraps 3->0 on the fourth byte.
- HDR state: assembles one header word. Bits [15:0] give N, the word count; bits [31:16] are ignored.
  - N == 0 -> DONE.
  - N > MAX_WORDS -> ERR.
  - Otherwise -> LOAD.
- LOAD state: on acceptance of the 4th byte of word k (0-based):
  - On the next cycle, mem_we = 1 for exactly one cycle.
  - mem_data = assembled word.
  - mem_addr = (BASE_ADDR + 4*k) mod 2^ADDR_W; wrap-around is silent.
  - words_loaded increments in that same cycle.
  - After word N-1 is written -> DONE (or CSUM when the feature is enabled).
- Back-to-back bytes: in_ready stays high during LOAD. Bytes may arrive every cycle; a write cycle never stalls the stream.
- in_ready: 1 in HDR, LOAD and CSUM; 0 in DONE and ERR.
- DONE state: cpu_run = 1, held until reset. mem_we stays 0.
- ERR state: load_err = 1, cpu_run = 0, held until reset.
- in_valid while in_ready = 0: ignored; no state change.
- Reset mid-word: discards any partial bytes and the count. Memory contents already written are not cleared.
- Latency: the last byte is accepted at edge T; mem_we is high in the cycle after T; cpu_run rises one cycle after that final mem_we.
- mem_data/mem_addr: hold their last written values when mem_we = 0.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- When defined:
  - After word N-1, the state goes to CSUM and one further 4-byte word is received. It is not written to memory.
  - The received word is compared to the XOR of the header word and all N data words.
  - Match -> DONE; mismatch -> ERR.
  - For N == 0, the checksum word is still required and must equal the header word.
- When undefined: no CSUM state. The transition after the last word, or after N == 0, goes directly to DONE.

Test Plan:
- Header 00000002, words 20080005, 2009000A, back-to-back bytes -> two mem_we pulses: addr 0x000 data 20080005, then addr 0x004 data 2009000A. cpu_run = 1 one cycle after the second pulse; words_loaded = 2.
- Same image with in_valid toggling every other cycle -> identical writes and values; in_ready never drops before DONE.
- Header 00000000 -> no mem_we. cpu_run = 1 (feature off); in_ready = 0 afterwards.
- Header 00000101 (257 > MAX_WORDS) -> load_err = 1, cpu_run stays 0, in_ready = 0. Further bytes are ignored.
- Reset asserted after 2 bytes of word 1 -> outputs clear, state HDR. A fresh 1-word image then loads to addr 0x000.
- With PROG_LOADER_CHECKSUM_EN: header 00000001, word 12345678, checksum 12345679 -> DONE. Checksum 00000000 -> load_err = 1.
